// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: splits one mining job's nonce range across N_CORES hash cores.
// Lane i tries nonce_base+i, +N_CORES, +2*N_CORES, ... (2^RANGE_W/N_CORES nonces per lane).
// The first hit (lowest lane on a tie) or range exhaustion is reported through a
// valid/ack handshake.
//
// Ports:
//   clock_i             system clock
//   reset_ni            asynchronous active-low reset
//   start_i             one-cycle job start, sampled in idle only
//   abort_i             one-cycle job cancel (launch/run only)
//   nonce_base_i        first nonce of the job, sampled with start_i
//   core_start_o        per-lane one-cycle launch pulse
//   core_nonce_o        lane i nonce at [i*NONCE_W +: NONCE_W]
//   core_done_i         per-lane completion pulse
//   core_found_i        per-lane hit flag, valid with core_done_i
//   core_kill_o         one-cycle pulse: all cores drop work
//   busy_o              job in launch/run
//   result_valid_o      result held until result_ack_i
//   result_nonce_o      winning nonce (0 when exhausted)
//   result_exhausted_o  job ended without a hit
//   result_ack_i        processor consumes the result
//   nonces_tried_o      saturating count of accepted core_done pulses this job
module nonce_dispatcher #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned NONCE_W = 32,
    parameter int unsigned RANGE_W = 20
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [NONCE_W-1:0]         nonce_base_i,
    output logic [N_CORES-1:0]         core_start_o,
    output logic [N_CORES*NONCE_W-1:0] core_nonce_o,
    input  logic [N_CORES-1:0]         core_done_i,
    input  logic [N_CORES-1:0]         core_found_i,
    output logic                       core_kill_o,
    output logic                       busy_o,
    output logic                       result_valid_o,
    output logic [NONCE_W-1:0]         result_nonce_o,
    output logic                       result_exhausted_o,
    input  logic                       result_ack_i,
    output logic [31:0]                nonces_tried_o
);

    localparam int unsigned LaneLen = (32'd1 << RANGE_W) / N_CORES;
    localparam int unsigned CntW    = $clog2(N_CORES + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StRun, StReport} state_e;

    state_e                            state_q, state_d;
    logic [N_CORES-1:0][NONCE_W-1:0]   lane_nonce_q, lane_nonce_d;
    logic [N_CORES-1:0][RANGE_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [N_CORES-1:0]                lane_active_q, lane_active_d;
    logic [N_CORES-1:0]                core_start_q, core_start_d;
    logic                              core_kill_q, core_kill_d;
    logic                              result_valid_q, result_valid_d;
    logic [NONCE_W-1:0]                result_nonce_q, result_nonce_d;
    logic                              result_exh_q, result_exh_d;
    logic [31:0]                       tried_q, tried_d;

    logic [N_CORES-1:0]                done_eff;
    logic [N_CORES-1:0]                hit;
    logic [CntW-1:0]                   done_cnt;
    logic [32:0]                       tried_sum;
    logic [31:0]                       tried_sat;
    logic [NONCE_W-1:0]                win_nonce;

    // Dones on retired lanes are ignored entirely (neither counted nor a hit).
    assign done_eff = core_done_i & lane_active_q;
    assign hit      = done_eff & core_found_i;

    // Popcount of accepted dones and lowest-index winning nonce.
    always_comb begin
        done_cnt  = '0;
        win_nonce = '0;
        for (int i = int'(N_CORES) - 1; i >= 0; i--) begin
            done_cnt = done_cnt + CntW'(done_eff[i]);
            if (hit[i]) begin
                win_nonce = lane_nonce_q[i];
            end
        end
    end

    assign tried_sum = {1'b0, tried_q} + 33'(done_cnt);
    assign tried_sat = tried_sum[32] ? 32'hFFFF_FFFF : tried_sum[31:0];

    always_comb begin
        state_d        = state_q;
        lane_nonce_d   = lane_nonce_q;
        lane_cnt_d     = lane_cnt_q;
        lane_active_d  = lane_active_q;
        core_start_d   = '0;
        core_kill_d    = 1'b0;
        result_valid_d = result_valid_q;
        result_nonce_d = result_nonce_q;
        result_exh_d   = result_exh_q;
        tried_d        = tried_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d        = StLaunch;
                    tried_d        = '0;
                    result_nonce_d = '0;
                    result_exh_d   = 1'b0;
                    for (int i = 0; i < int'(N_CORES); i++) begin
                        lane_nonce_d[i]  = nonce_base_i + NONCE_W'(i);
                        lane_cnt_d[i]    = '0;
                        lane_active_d[i] = 1'b1;
                    end
                end
            end
            StLaunch: begin
                if (abort_i) begin
                    core_kill_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    core_start_d = '1;
                    state_d      = StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    // Abort wins over a same-cycle hit or exhaustion.
                    core_kill_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    tried_d = tried_sat;
                    if (|hit) begin
                        result_nonce_d = win_nonce;
                        result_exh_d   = 1'b0;
                        result_valid_d = 1'b1;
                        core_kill_d    = 1'b1;
                        state_d        = StReport;
                    end else begin
                        for (int i = 0; i < int'(N_CORES); i++) begin
                            if (done_eff[i]) begin
                                lane_cnt_d[i] = lane_cnt_q[i] + RANGE_W'(1);
                                if ((32'(lane_cnt_q[i]) + 32'd1) < LaneLen) begin
                                    lane_nonce_d[i] = lane_nonce_q[i] + NONCE_W'(N_CORES);
                                    core_start_d[i] = 1'b1;
                                end else begin
                                    lane_active_d[i] = 1'b0;
                                end
                            end
                        end
                        if (lane_active_d == '0) begin
                            result_nonce_d = '0;
                            result_exh_d   = 1'b1;
                            result_valid_d = 1'b1;
                            state_d        = StReport;
                        end
                    end
                end
            end
            StReport: begin
                if (result_ack_i) begin
                    result_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= StIdle;
            lane_nonce_q   <= '0;
            lane_cnt_q     <= '0;
            lane_active_q  <= '0;
            core_start_q   <= '0;
            core_kill_q    <= 1'b0;
            result_valid_q <= 1'b0;
            result_nonce_q <= '0;
            result_exh_q   <= 1'b0;
            tried_q        <= '0;
        end else begin
            state_q        <= state_d;
            lane_nonce_q   <= lane_nonce_d;
            lane_cnt_q     <= lane_cnt_d;
            lane_active_q  <= lane_active_d;
            core_start_q   <= core_start_d;
            core_kill_q    <= core_kill_d;
            result_valid_q <= result_valid_d;
            result_nonce_q <= result_nonce_d;
            result_exh_q   <= result_exh_d;
            tried_q        <= tried_d;
        end
    end

    assign core_start_o       = core_start_q;
    assign core_nonce_o       = lane_nonce_q;
    assign core_kill_o        = core_kill_q;
    assign busy_o             = (state_q == StLaunch) || (state_q == StRun);
    assign result_valid_o     = result_valid_q;
    assign result_nonce_o     = result_nonce_q;
    assign result_exhausted_o = result_exh_q;
    assign nonces_tried_o     = tried_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher (N_CORES=4, RANGE_W=4 -> 4 nonces per lane).
// Behavioural cores answer each launch after a configurable latency; the expected
// result is derived from what the bench itself drove.
module tb_nonce_dispatcher;
    localparam int unsigned NC = 4;
    localparam int unsigned NW = 32;
    localparam int unsigned RW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           ack = 1'b0;
    logic [31:0]    base_in = '0;
    logic [3:0]     core_start;
    logic [3:0]     core_done = '0;
    logic [3:0]     core_found = '0;
    logic [127:0]   core_nonce;
    logic           kill, busy, rv, rexh;
    logic [31:0]    rnonce, tried;

    nonce_dispatcher #(.N_CORES(NC), .NONCE_W(NW), .RANGE_W(RW)) dut (
        .clock_i            (clk),
        .reset_ni           (rst_n),
        .start_i            (start),
        .abort_i            (abort),
        .nonce_base_i       (base_in),
        .core_start_o       (core_start),
        .core_nonce_o       (core_nonce),
        .core_done_i        (core_done),
        .core_found_i       (core_found),
        .core_kill_o        (kill),
        .busy_o             (busy),
        .result_valid_o     (rv),
        .result_nonce_o     (rnonce),
        .result_exhausted_o (rexh),
        .result_ack_i       (ack),
        .nonces_tried_o     (tried)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Core model configuration and state.
    int lat_cfg[4];
    bit rand_lat;
    int hit_k[4];     // index k of the lane's nonce that hits; -1 = never
    bit pending[4];
    int cdown[4];
    int kcur[4];
    int kiss[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_core_start"}, 64'(core_start), 64'h0);
        chk({tag, "_core_nonce_lo"}, core_nonce[63:0], 64'h0);
        chk({tag, "_core_nonce_hi"}, core_nonce[127:64], 64'h0);
        chk({tag, "_kill"}, 64'(kill), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_valid"}, 64'(rv), 64'h0);
        chk({tag, "_nonce"}, 64'(rnonce), 64'h0);
        chk({tag, "_exh"}, 64'(rexh), 64'h0);
        chk({tag, "_tried"}, 64'(tried), 64'h0);
    endtask

    // Runs one job. abort_at >= 0 aborts in that cycle; hold keeps the result un-acked
    // for 10 cycles while pulsing start.
    task automatic run_job(input logic [31:0] base, input int abort_at, input bit hold);
        int c;
        int done_total;
        int final_c;
        int kills;
        int starts_after;
        int exp_tried;
        bit hit_seen;
        bit got;
        bit any;
        logic [31:0] exp_nonce;
        logic [31:0] want;
        c = 1; done_total = 0; final_c = -1; kills = 0; starts_after = 0;
        exp_tried = 0; hit_seen = 0; got = 0; exp_nonce = '0;
        for (int i = 0; i < 4; i++) begin
            pending[i] = 0;
            kiss[i] = 0;
            kcur[i] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        base_in = base;
        @(negedge clk);
        start = 1'b0;
        chk("launch_busy", 64'(busy), 64'h1);
        chk("launch_no_start", 64'(core_start), 64'h0);
        while (c < 300 && !got) begin
            @(negedge clk);
            c++;
            core_done = '0;
            core_found = '0;
            if (kill) kills++;
            if (rv) begin
                got = 1;
            end else begin
                if (c == 2) chk("first_launch_all", 64'(core_start), 64'hF);
                if (c == abort_at) begin
                    abort = 1'b1;
                end else if (!hit_seen) begin
                    for (int i = 0; i < 4; i++) begin
                        if (pending[i]) begin
                            cdown[i]--;
                            if (cdown[i] == 0) begin
                                core_done[i] = 1'b1;
                                core_found[i] = (hit_k[i] == kcur[i]);
                                pending[i] = 0;
                                done_total++;
                            end
                        end
                    end
                    any = 0;
                    for (int i = 3; i >= 0; i--) begin
                        if (core_done[i] && core_found[i]) begin
                            any = 1;
                            exp_nonce = base + 32'(i) + 32'(4 * kcur[i]);
                        end
                    end
                    if (any) begin
                        hit_seen = 1;
                        final_c = c;
                        exp_tried = done_total;
                    end else if (done_total == 16) begin
                        final_c = c;
                        exp_tried = 16;
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (core_start[i]) begin
                        if (final_c >= 0 && c > final_c) begin
                            starts_after++;
                        end else begin
                            want = base + 32'(i) + 32'(4 * kiss[i]);
                            chk("lane_nonce", 64'(core_nonce[i*32 +: 32]), 64'(want));
                            pending[i] = 1;
                            kcur[i] = kiss[i];
                            kiss[i]++;
                            cdown[i] = rand_lat ? int'($urandom_range(4, 1)) : lat_cfg[i];
                        end
                    end
                end
                if (c == abort_at) begin
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_kill", 64'(kill), 64'h1);
                    chk("abort_busy", 64'(busy), 64'h0);
                    chk("abort_valid", 64'(rv), 64'h0);
                    repeat (4) begin
                        @(negedge clk);
                        chk("abort_valid_after", 64'(rv), 64'h0);
                        chk("abort_kill_after", 64'(kill), 64'h0);
                    end
                    return;
                end
            end
        end
        if (!got) begin
            chk("timeout_result_valid", 64'h0, 64'h1);
            return;
        end
        chk("result_latency", 64'(c), 64'(final_c + 1));
        chk("result_nonce", 64'(rnonce), 64'(exp_nonce));
        chk("result_exhausted", 64'(rexh), 64'(!hit_seen));
        chk("nonces_tried", 64'(tried), 64'(exp_tried));
        chk("kill_count", 64'(kills), 64'(hit_seen));
        chk("report_busy", 64'(busy), 64'h0);
        if (hit_seen) begin
            chk("starts_after_hit", 64'(starts_after), 64'h0);
        end else begin
            for (int i = 0; i < 4; i++) chk("lane_dispatches", 64'(kiss[i]), 64'h4);
        end
        if (hold) begin
            repeat (10) begin
                @(negedge clk);
                start = ~start;
                base_in = $urandom;
                chk("hold_valid", 64'(rv), 64'h1);
                chk("hold_nonce", 64'(rnonce), 64'(exp_nonce));
                chk("hold_no_start", 64'(core_start), 64'h0);
                chk("hold_busy", 64'(busy), 64'h0);
                chk("hold_kill", 64'(kill), 64'h0);
            end
            start = 1'b0;
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_valid_cleared", 64'(rv), 64'h0);
        chk("kill_one_cycle", 64'(kill), 64'h0);
    endtask

    initial begin
        rand_lat = 0;
        for (int i = 0; i < 4; i++) begin
            lat_cfg[i] = 3;
            hit_k[i] = -1;
        end
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Exhaustion from base 0x100.
        run_job(32'h100, -1, 0);

        // Lane 2 hits on its second nonce (0x106).
        hit_k[2] = 1;
        run_job(32'h100, -1, 0);

        // Lanes 1 and 3 hit together; lanes 0 and 2 are still working.
        lat_cfg[0] = 5; lat_cfg[2] = 5;
        hit_k[2] = -1; hit_k[1] = 0; hit_k[3] = 0;
        run_job(32'h100, -1, 0);

        // Wrap-around of the nonce space.
        for (int i = 0; i < 4; i++) begin
            lat_cfg[i] = 3;
            hit_k[i] = -1;
        end
        run_job(32'hFFFF_FFFE, -1, 0);

        // Mid-job abort.
        run_job(32'h300, 6, 0);

        // Asynchronous reset in the middle of a job.
        @(negedge clk);
        start = 1'b1;
        base_in = 32'h200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'h1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Held report with start pulses, then a fresh job is accepted.
        hit_k[0] = 2;
        run_job(32'h400, -1, 1);
        hit_k[0] = -1;
        run_job(32'h500, -1, 0);

        // Randomised jobs.
        rand_lat = 1;
        repeat (10) begin
            for (int i = 0; i < 4; i++) begin
                hit_k[i] = ($urandom_range(2, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            end
            run_job($urandom, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
